// File: rtl/m8_frame_sequencer.sv
// m8_frame_sequencer: paces the M8 word filler.
// - Opens one word slot every WORD_DIV clocks.
// - Issues a single-cycle fetch strobe together with the read pointer.
// - Captures the filler word and offers it downstream over valid/ready.
// - Tracks frame boundaries, a completed-frame count and slot overruns.
// Optional build macro SYNC_MARKER_EN: when defined, word 0 of each frame is
// replaced by SYNC_WORD. The filler is still strobed, so its counters stay aligned.
module m8_frame_sequencer #(
   parameter int                WORDS_PER_FRAME = 1024,
   parameter int                PTR_W           = 10,
   parameter int                DATA_W          = 12,
   parameter int                WORD_DIV        = 64,
   parameter logic [DATA_W-1:0] SYNC_WORD       = 12'hFA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              clrErr,
   output logic              bufGetWord,
   output logic [PTR_W-1:0]  bufRdPointer,
   input  logic [DATA_W-1:0] dataWord,
   output logic [DATA_W-1:0] wordOut,
   output logic              wordValid,
   input  logic              wordReady,
   output logic              frameStart,
   output logic [15:0]       frameCnt,
   output logic              overrun
);

   localparam int               CNT_W    = (WORD_DIV > 1) ? $clog2(WORD_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIV - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS_PER_FRAME - 1);

   // Reject parameter sets the sequencer cannot honour: slot too short for the
   // four-state word sequence, or a pointer too narrow for the frame.
   if (WORD_DIV < 4 || (2 ** PTR_W) < WORDS_PER_FRAME || $bits(SYNC_WORD) != DATA_W) begin : g_cfg_check
      $error("m8_frame_sequencer: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      OFFER   = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    slotCnt;
   logic                slotTick;
   logic [DATA_W-1:0]   capWord;

   // Pointer advance with wrap at the last word of the frame.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign slotTick = enable && (slotCnt == LAST_CNT);

`ifdef SYNC_MARKER_EN
   assign capWord = (bufRdPointer == '0) ? SYNC_WORD : dataWord;
`else
   assign capWord = dataWord;
`endif

   // Slot timer: free-runs 0..WORD_DIV-1 while enabled, parked at 0 otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slotCnt <= '0;
      end else if (!enable || slotTick) begin
         slotCnt <= '0;
      end else begin
         slotCnt <= slotCnt + CNT_W'(1);
      end
   end

   // Word FSM with registered strobe, pointer, output word and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bufGetWord   <= 1'b0;
         bufRdPointer <= '0;
         wordOut      <= '0;
         wordValid    <= 1'b0;
         frameStart   <= 1'b0;
         frameCnt     <= '0;
         overrun      <= 1'b0;
      end else begin
         // Strobes are single-cycle by construction: only IDLE->ISSUE raises them.
         bufGetWord <= 1'b0;
         frameStart <= 1'b0;

         // A slot that arrives while a word is still in flight is dropped, not
         // queued; a new overrun outranks a simultaneous clear.
         if (slotTick && state != IDLE) begin
            overrun <= 1'b1;
         end else if (clrErr) begin
            overrun <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (slotTick) begin
                  state      <= ISSUE;
                  bufGetWord <= 1'b1;
                  frameStart <= (bufRdPointer == '0);
               end else if (!enable) begin
                  bufRdPointer <= '0;
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               wordOut   <= capWord;
               wordValid <= 1'b1;
               state     <= OFFER;
            end
            OFFER: begin
               if (wordReady) begin
                  wordValid    <= 1'b0;
                  bufRdPointer <= ptr_next(bufRdPointer);
                  if (bufRdPointer == LAST_PTR) begin
                     frameCnt <= frameCnt + 16'd1;
                  end
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m8_frame_sequencer.sv
// Directed bench for m8_frame_sequencer (WORD_DIV=64, 16-word frames).
module tb_m8_frame_sequencer;

   localparam int WPF    = 16;
   localparam int PTR_W  = 10;
   localparam int DATA_W = 12;
   localparam int WDIV   = 64;
`ifdef SYNC_MARKER_EN
   localparam logic SYNC_ON = 1'b1;
`else
   localparam logic SYNC_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              clrErr = 1'b0;
   logic              bufGetWord;
   logic [PTR_W-1:0]  bufRdPointer;
   logic [DATA_W-1:0] dataWord = '0;
   logic [DATA_W-1:0] wordOut;
   logic              wordValid;
   logic              wordReady = 1'b1;
   logic              frameStart;
   logic [15:0]       frameCnt;
   logic              overrun;

   int n_chk = 0;
   int n_pass = 0;

   m8_frame_sequencer #(
      .WORDS_PER_FRAME(WPF),
      .PTR_W(PTR_W),
      .DATA_W(DATA_W),
      .WORD_DIV(WDIV),
      .SYNC_WORD(12'hFA5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .clrErr(clrErr),
      .bufGetWord(bufGetWord),
      .bufRdPointer(bufRdPointer),
      .dataWord(dataWord),
      .wordOut(wordOut),
      .wordValid(wordValid),
      .wordReady(wordReady),
      .frameStart(frameStart),
      .frameCnt(frameCnt),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Filler content: word p holds 12'h00A + 3*p.
   function automatic logic [DATA_W-1:0] fill(input int p);
      return 12'h00A + DATA_W'(p * 3);
   endfunction

   function automatic logic [DATA_W-1:0] expw(input int p);
      return (SYNC_ON && p == 0) ? 12'hFA5 : fill(p);
   endfunction

   // Filler model: registered word appears the cycle after the strobe.
   always @(posedge clk) begin
      if (bufGetWord) dataWord <= fill(int'(bufRdPointer));
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic wait_strobe(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bufGetWord && n < 300);
      check(tag, 32'(bufGetWord), 32'd1);
   endtask

   initial begin
      int n;
      int bad;
      int strobes;
      logic [DATA_W-1:0] held;

      // Reset state
      @(negedge clk);
      check("rst_get",    32'(bufGetWord),   32'd0);
      check("rst_ptr",    32'(bufRdPointer), 32'd0);
      check("rst_valid",  32'(wordValid),    32'd0);
      check("rst_word",   32'(wordOut),      32'd0);
      check("rst_fstart", 32'(frameStart),   32'd0);
      check("rst_fcnt",   32'(frameCnt),     32'd0);
      check("rst_ovr",    32'(overrun),      32'd0);

      // First word: strobe 64 clocks after enable, valid two clocks later
      reset  = 1'b1;
      enable = 1'b1;
      wait_strobe("first_strobe", n);
      check("first_lat",    32'(n),            32'd64);
      check("first_ptr",    32'(bufRdPointer), 32'd0);
      check("first_fstart", 32'(frameStart),   32'd1);
      @(negedge clk);
      check("strobe_1cyc",  32'(bufGetWord),   32'd0);
      check("valid_early",  32'(wordValid),    32'd0);
      @(negedge clk);
      check("first_valid",  32'(wordValid),    32'd1);
      check("first_word",   32'(wordOut),      32'(expw(0)));
      @(negedge clk);
      check("first_done",   32'(wordValid),    32'd0);
      check("ptr_after",    32'(bufRdPointer), 32'd1);

      // Free run across a frame wrap
      for (int w = 1; w <= WPF; w++) begin
         wait_strobe("run_strobe", n);
         if (w >= 2) check("run_period", 32'(n), 32'd62);
         check("run_ptr",    32'(bufRdPointer), 32'(w % WPF));
         check("run_fstart", 32'(frameStart),   32'((w % WPF) == 0));
         if (w == WPF - 1) check("fcnt_before", 32'(frameCnt), 32'd0);
         if (w == WPF)     check("fcnt_after",  32'(frameCnt), 32'd1);
         repeat (2) @(negedge clk);
         check("run_valid", 32'(wordValid), 32'd1);
         check("run_word",  32'(wordOut),   32'(expw(w % WPF)));
      end
      check("run_ovr", 32'(overrun), 32'd0);

      // Downstream stall for 100 clocks -> overrun, skipped slot
      wait_strobe("stall_strobe", n);
      check("stall_ptr", 32'(bufRdPointer), 32'd1);
      wordReady = 1'b0;
      repeat (2) @(negedge clk);
      check("stall_valid", 32'(wordValid), 32'd1);
      check("stall_word",  32'(wordOut),   32'(expw(1)));
      held = wordOut;
      bad = 0;
      strobes = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wordValid !== 1'b1 || wordOut !== held) bad++;
         if (bufGetWord) strobes++;
      end
      check("stall_stable",  32'(bad),     32'd0);
      check("stall_nostrb",  32'(strobes), 32'd0);
      check("stall_ovr",     32'(overrun), 32'd1);
      wordReady = 1'b1;
      @(negedge clk);
      check("stall_release", 32'(wordValid),    32'd0);
      check("stall_ptr2",    32'(bufRdPointer), 32'd2);
      clrErr = 1'b1;
      @(negedge clk);
      clrErr = 1'b0;
      check("ovr_cleared",   32'(overrun),      32'd0);
      wait_strobe("post_stall", n);
      check("post_stall_lat", 32'(n),            32'd24);
      check("post_stall_ptr", 32'(bufRdPointer), 32'd2);

      // Drop enable during OFFER at pointer 5
      for (int i = 0; i < 3; i++) wait_strobe("to_ptr5", n);
      check("ptr5", 32'(bufRdPointer), 32'd5);
      wordReady = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("dis_valid_held", 32'(wordValid),    32'd1);
      check("dis_ptr_held",   32'(bufRdPointer), 32'd5);
      wordReady = 1'b1;
      @(negedge clk);
      check("dis_handshake",  32'(wordValid),    32'd0);
      check("dis_ptr_adv",    32'(bufRdPointer), 32'd6);
      @(negedge clk);
      check("dis_ptr_zero",   32'(bufRdPointer), 32'd0);
      strobes = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bufGetWord) strobes++;
      end
      check("dis_nostrb", 32'(strobes), 32'd0);
      enable = 1'b1;
      wait_strobe("reen_strobe", n);
      check("reen_lat",    32'(n),            32'd64);
      check("reen_ptr",    32'(bufRdPointer), 32'd0);
      check("reen_fstart", 32'(frameStart),   32'd1);
      check("reen_fcnt",   32'(frameCnt),     32'd1);
      check("reen_ovr",    32'(overrun),      32'd0);

      // Reset during CAPTURE
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rc_valid", 32'(wordValid),    32'd0);
      check("rc_get",   32'(bufGetWord),   32'd0);
      check("rc_fcnt",  32'(frameCnt),     32'd0);
      check("rc_ptr",   32'(bufRdPointer), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_strobe("rc_strobe", n);
      check("rc_lat",    32'(n),            32'd64);
      check("rc_ptr0",   32'(bufRdPointer), 32'd0);
      check("rc_fstart", 32'(frameStart),   32'd1);

      // Reset during OFFER drops wordValid without a clock edge
      wordReady = 1'b0;
      repeat (2) @(negedge clk);
      check("ro_valid", 32'(wordValid), 32'd1);
      check("ro_word",  32'(wordOut),   32'(expw(0)));
      #2 reset = 1'b0;
      #1;
      check("ro_async_valid", 32'(wordValid), 32'd0);
      check("ro_async_word",  32'(wordOut),   32'd0);
      @(negedge clk);
      reset = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
